dcache_req_arbiter: RTL and testbench

// Shares the single HPDcache core request port between the LSU (via dcache_interface) and the

---
 rtl/dcache_req_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_dcache_req_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_arbiter.sv
// ============================================================================
// Module   : dcache_req_arbiter
// Purpose  : Shares the HPDcache core request port between LSU and PTW, tags
//            requests with the owner SID, routes responses by SID and tracks
//            per-requester outstanding requests with a drain handshake.
//            Optional LSU anti-starvation: define DCACHE_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_req_arbiter_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  op;
        logic [3:0]  be;
        logic [2:0]  sid;
        logic [3:0]  tid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [2:0]  sid;
        logic [3:0]  tid;
        logic        error;
    } hpdcache_rsp_t;
endpackage

module dcache_req_arbiter
    import dcache_req_arbiter_pkg::*;
#(
    parameter logic [2:0] SID_LSU         = 3'b001,
    parameter logic [2:0] SID_PTW         = 3'b010,
    parameter int         MAX_OUTSTANDING = 4,
    parameter int         STARVE_LIMIT    = 8
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          lsu_req_valid_i,
    input  hpdcache_req_t lsu_req_i,
    output logic          lsu_req_ready_o,
    input  logic          ptw_req_valid_i,
    input  hpdcache_req_t ptw_req_i,
    output logic          ptw_req_ready_o,
    output logic          dc_req_valid_o,
    output hpdcache_req_t dc_req_o,
    input  logic          dc_req_ready_i,
    input  logic          dc_rsp_valid_i,
    input  hpdcache_rsp_t dc_rsp_i,
    output logic          lsu_rsp_valid_o,
    output logic          ptw_rsp_valid_o,
    output hpdcache_rsp_t rsp_o,
    input  logic          drain_req_i,
    output logic          drained_o,
    output logic          err_sid_o
);

    localparam logic [2:0] c_MAX = 3'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_last_grant;      // 1 = PTW, 0 = LSU; also the HOLD owner
    logic [2:0]    r_lsu_cnt;
    logic [2:0]    r_ptw_cnt;
    logic [2:0]    w_lsu_cnt_nxt;
    logic [2:0]    w_ptw_cnt_nxt;
    logic          r_drained;

    logic          w_arb_en;
    logic          w_lsu_room;
    logic          w_ptw_room;
    logic          w_lsu_elig;
    logic          w_ptw_elig;
    logic          w_force_lsu;
    logic          w_grant_lsu;
    logic          w_grant_ptw;
    logic          w_owner_ptw;
    logic          w_dc_valid;
    logic          w_accept;
    logic          w_lsu_acc;
    logic          w_ptw_acc;
    logic          w_rsp_lsu;
    logic          w_rsp_ptw;
    logic          w_rsp_unk;
    logic          w_lsu_uf;
    logic          w_ptw_uf;
    hpdcache_req_t w_req;

    assign w_arb_en   = (r_state == ST_ARB) & ~drain_req_i;
    assign w_lsu_room = (r_lsu_cnt < c_MAX);
    assign w_ptw_room = (r_ptw_cnt < c_MAX);
    assign w_lsu_elig = lsu_req_valid_i & w_lsu_room & w_arb_en;
    assign w_ptw_elig = ptw_req_valid_i & w_ptw_room & w_arb_en;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
    localparam int c_STARVE_W = (STARVE_LIMIT < 8) ? 3 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    logic [c_STARVE_W-1:0] r_starve_cnt;

    assign w_force_lsu = w_lsu_elig & (r_starve_cnt >= c_STARVE_MAX);

    // Counts PTW accepts that happened while the LSU could have gone instead
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_starve_cnt <= '0;
        end else if (w_lsu_acc) begin
            r_starve_cnt <= '0;
        end else if (w_ptw_acc & lsu_req_valid_i & w_lsu_room &
                     (r_starve_cnt < c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_force_lsu = 1'b0;
`endif

    assign w_grant_ptw = w_ptw_elig & ~w_force_lsu;
    assign w_grant_lsu = w_lsu_elig & ~w_grant_ptw;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_ptw = r_last_grant;
        w_dc_valid  = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (w_grant_ptw | w_grant_lsu) begin
                    w_dc_valid  = 1'b1;
                    w_owner_ptw = w_grant_ptw;
                    if (!dc_req_ready_i) begin
                        w_state_nxt = ST_HOLD;
                    end
                end else if (drain_req_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                w_dc_valid = 1'b1;
                if (dc_req_ready_i) begin
                    w_state_nxt = drain_req_i ? ST_DRAIN : ST_ARB;
                end
            end
            ST_DRAIN: begin
                if (!drain_req_i) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_comb begin
        w_req     = w_owner_ptw ? ptw_req_i : lsu_req_i;
        w_req.sid = w_owner_ptw ? SID_PTW : SID_LSU;
    end

    assign w_accept        = w_dc_valid & dc_req_ready_i;
    assign w_lsu_acc       = w_accept & ~w_owner_ptw;
    assign w_ptw_acc       = w_accept & w_owner_ptw;
    assign dc_req_valid_o  = w_dc_valid;
    assign dc_req_o        = w_req;
    assign lsu_req_ready_o = w_lsu_acc;
    assign ptw_req_ready_o = w_ptw_acc;

    assign w_rsp_lsu       = dc_rsp_valid_i & (dc_rsp_i.sid == SID_LSU);
    assign w_rsp_ptw       = dc_rsp_valid_i & (dc_rsp_i.sid == SID_PTW);
    assign w_rsp_unk       = dc_rsp_valid_i & ~w_rsp_lsu & ~w_rsp_ptw;
    // A same-cycle accept balances the response, so it is not an underflow
    assign w_lsu_uf        = w_rsp_lsu & (r_lsu_cnt == 3'd0) & ~w_lsu_acc;
    assign w_ptw_uf        = w_rsp_ptw & (r_ptw_cnt == 3'd0) & ~w_ptw_acc;
    assign lsu_rsp_valid_o = w_rsp_lsu;
    assign ptw_rsp_valid_o = w_rsp_ptw;
    assign rsp_o           = dc_rsp_i;
    assign err_sid_o       = w_rsp_unk | w_lsu_uf | w_ptw_uf;

    always_comb begin
        w_lsu_cnt_nxt = r_lsu_cnt;
        w_ptw_cnt_nxt = r_ptw_cnt;
        if (w_lsu_acc & ~w_rsp_lsu) begin
            w_lsu_cnt_nxt = r_lsu_cnt + 3'd1;
        end else if (~w_lsu_acc & w_rsp_lsu & (r_lsu_cnt != 3'd0)) begin
            w_lsu_cnt_nxt = r_lsu_cnt - 3'd1;
        end
        if (w_ptw_acc & ~w_rsp_ptw) begin
            w_ptw_cnt_nxt = r_ptw_cnt + 3'd1;
        end else if (~w_ptw_acc & w_rsp_ptw & (r_ptw_cnt != 3'd0)) begin
            w_ptw_cnt_nxt = r_ptw_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_ARB;
            r_last_grant <= 1'b0;
            r_lsu_cnt    <= 3'd0;
            r_ptw_cnt    <= 3'd0;
            r_drained    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lsu_cnt <= w_lsu_cnt_nxt;
            r_ptw_cnt <= w_ptw_cnt_nxt;
            r_drained <= (w_state_nxt == ST_DRAIN) &
                         (w_lsu_cnt_nxt == 3'd0) & (w_ptw_cnt_nxt == 3'd0);
            if ((r_state == ST_ARB) & (w_grant_ptw | w_grant_lsu)) begin
                r_last_grant <= w_grant_ptw;
            end
        end
    end

    assign drained_o = r_drained;

endmodule

`default_nettype wire

// File: tb/tb_dcache_req_arbiter.sv
// ============================================================================
// Module   : tb_dcache_req_arbiter
// Purpose  : Scoreboard bench for dcache_req_arbiter with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_req_arbiter;
    import dcache_req_arbiter_pkg::*;

    localparam logic [2:0] c_SID_LSU = 3'b001;
    localparam logic [2:0] c_SID_PTW = 3'b010;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          lsu_req_valid_i;
    hpdcache_req_t lsu_req_i;
    logic          lsu_req_ready_o;
    logic          ptw_req_valid_i;
    hpdcache_req_t ptw_req_i;
    logic          ptw_req_ready_o;
    logic          dc_req_valid_o;
    hpdcache_req_t dc_req_o;
    logic          dc_req_ready_i;
    logic          dc_rsp_valid_i;
    hpdcache_rsp_t dc_rsp_i;
    logic          lsu_rsp_valid_o;
    logic          ptw_rsp_valid_o;
    hpdcache_rsp_t rsp_o;
    logic          drain_req_i;
    logic          drained_o;
    logic          err_sid_o;

    always #5 clk_i = ~clk_i;

    dcache_req_arbiter dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .lsu_req_valid_i (lsu_req_valid_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_req_ready_o (lsu_req_ready_o),
        .ptw_req_valid_i (ptw_req_valid_i),
        .ptw_req_i       (ptw_req_i),
        .ptw_req_ready_o (ptw_req_ready_o),
        .dc_req_valid_o  (dc_req_valid_o),
        .dc_req_o        (dc_req_o),
        .dc_req_ready_i  (dc_req_ready_i),
        .dc_rsp_valid_i  (dc_rsp_valid_i),
        .dc_rsp_i        (dc_rsp_i),
        .lsu_rsp_valid_o (lsu_rsp_valid_o),
        .ptw_rsp_valid_o (ptw_rsp_valid_o),
        .rsp_o           (rsp_o),
        .drain_req_i     (drain_req_i),
        .drained_o       (drained_o),
        .err_sid_o       (err_sid_o)
    );

    typedef struct packed {
        logic [2:0]  sid;
        logic [31:0] addr;
        logic        lsu_rdy;
        logic        ptw_rdy;
    } exp_req_t;

    typedef struct packed {
        logic        lsu_v;
        logic        ptw_v;
        logic        err;
        logic [31:0] rdata;
    } exp_rsp_t;

    exp_req_t q_req[$];
    exp_rsp_t q_rsp[$];
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic hpdcache_req_t mk(input logic [31:0] a);
        hpdcache_req_t r;
        r       = '0;
        r.addr  = a;
        r.wdata = ~a;
        r.sid   = 3'b111;
        return r;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT accepts a request or routes a response
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (dc_req_valid_o && dc_req_ready_i) begin
                if (q_req.size() == 0) begin
                    check("unexpected_accept", 32'(dc_req_o.addr), 32'hFFFF_FFFF);
                end else begin
                    exp_req_t e;
                    e = q_req.pop_front();
                    check("req_sid", 32'(dc_req_o.sid), 32'(e.sid));
                    check("req_addr", dc_req_o.addr, e.addr);
                    check("lsu_ready", 32'(lsu_req_ready_o), 32'(e.lsu_rdy));
                    check("ptw_ready", 32'(ptw_req_ready_o), 32'(e.ptw_rdy));
                end
            end else begin
                check("ready_idle", 32'({lsu_req_ready_o, ptw_req_ready_o}), 32'd0);
            end
            if (dc_rsp_valid_i) begin
                if (q_rsp.size() == 0) begin
                    check("unexpected_rsp", rsp_o.rdata, 32'hFFFF_FFFF);
                end else begin
                    exp_rsp_t r;
                    r = q_rsp.pop_front();
                    check("lsu_rsp_valid", 32'(lsu_rsp_valid_o), 32'(r.lsu_v));
                    check("ptw_rsp_valid", 32'(ptw_rsp_valid_o), 32'(r.ptw_v));
                    check("err_sid", 32'(err_sid_o), 32'(r.err));
                    check("rsp_rdata", rsp_o.rdata, r.rdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_req(input logic [2:0] sid, input logic [31:0] a, input logic lr, input logic pr);
        exp_req_t e;
        e.sid = sid; e.addr = a; e.lsu_rdy = lr; e.ptw_rdy = pr;
        q_req.push_back(e);
    endtask

    task automatic rsp(input logic [2:0] sid, input logic [31:0] d,
                       input logic lv, input logic pv, input logic er);
        exp_rsp_t r;
        dc_rsp_valid_i = 1'b1;
        dc_rsp_i       = '0;
        dc_rsp_i.sid   = sid;
        dc_rsp_i.rdata = d;
        r.lsu_v = lv; r.ptw_v = pv; r.err = er; r.rdata = d;
        q_rsp.push_back(r);
    endtask

    initial begin
        rstn_i          = 1'b0;
        lsu_req_valid_i = 1'b0;
        ptw_req_valid_i = 1'b0;
        lsu_req_i       = '0;
        ptw_req_i       = '0;
        dc_req_ready_i  = 1'b0;
        dc_rsp_valid_i  = 1'b0;
        dc_rsp_i        = '0;
        drain_req_i     = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_dc_valid", 32'(dc_req_valid_o), 32'd0);
        check("rst_readies", 32'({lsu_req_ready_o, ptw_req_ready_o}), 32'd0);
        check("rst_rsp_valid", 32'({lsu_rsp_valid_o, ptw_rsp_valid_o}), 32'd0);
        check("rst_drained", 32'(drained_o), 32'd0);
        check("rst_err", 32'(err_sid_o), 32'd0);
        step();
        rstn_i = 1'b1;

        // 1: both valid, PTW wins
        lsu_req_valid_i = 1'b1; lsu_req_i = mk(32'h100);
        ptw_req_valid_i = 1'b1; ptw_req_i = mk(32'h200);
        dc_req_ready_i  = 1'b1;
        push_req(c_SID_PTW, 32'h200, 1'b0, 1'b1);
        push_req(c_SID_LSU, 32'h100, 1'b1, 1'b0);
        step();
        ptw_req_valid_i = 1'b0;
        step();
        lsu_req_valid_i = 1'b0; dc_req_ready_i = 1'b0;
        rsp(c_SID_PTW, 32'hA1, 1'b0, 1'b1, 1'b0); step();
        rsp(c_SID_LSU, 32'hA2, 1'b1, 1'b0, 1'b0); step();
        dc_rsp_valid_i = 1'b0;

        // 2: held LSU grant survives a later PTW request
        lsu_req_valid_i = 1'b1; lsu_req_i = mk(32'h300);
        @(negedge clk_i);
        check("t2_valid", 32'(dc_req_valid_o), 32'd1);
        check("t2_sid_c0", 32'(dc_req_o.sid), 32'(c_SID_LSU));
        step();
        ptw_req_valid_i = 1'b1; ptw_req_i = mk(32'h400);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            check("t2_hold_sid", 32'(dc_req_o.sid), 32'(c_SID_LSU));
            check("t2_hold_addr", dc_req_o.addr, 32'h300);
            step();
        end
        dc_req_ready_i = 1'b1;
        push_req(c_SID_LSU, 32'h300, 1'b1, 1'b0);
        step();
        lsu_req_valid_i = 1'b0;
        push_req(c_SID_PTW, 32'h400, 1'b0, 1'b1);
        step();
        ptw_req_valid_i = 1'b0; dc_req_ready_i = 1'b0;
        rsp(c_SID_LSU, 32'hB1, 1'b1, 1'b0, 1'b0); step();
        rsp(c_SID_PTW, 32'hB2, 1'b0, 1'b1, 1'b0); step();
        dc_rsp_valid_i = 1'b0;

        // 3: outstanding limit
        dc_req_ready_i = 1'b1; lsu_req_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lsu_req_i = mk(32'h500 + 32'(i));
            push_req(c_SID_LSU, 32'h500 + 32'(i), 1'b1, 1'b0);
            step();
        end
        lsu_req_i = mk(32'h504);
        @(negedge clk_i);
        check("t3_blocked", 32'(dc_req_valid_o), 32'd0);
        step();
        rsp(c_SID_LSU, 32'hC0, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        check("t3_blocked_rsp_cycle", 32'(dc_req_valid_o), 32'd0);
        step();
        dc_rsp_valid_i = 1'b0;
        push_req(c_SID_LSU, 32'h504, 1'b1, 1'b0);
        step();
        lsu_req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rsp(c_SID_LSU, 32'hC1 + 32'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        dc_rsp_valid_i = 1'b0;

        // 4: drain with two LSU requests in flight
        lsu_req_valid_i = 1'b1;
        lsu_req_i = mk(32'h600); push_req(c_SID_LSU, 32'h600, 1'b1, 1'b0); step();
        lsu_req_i = mk(32'h601); push_req(c_SID_LSU, 32'h601, 1'b1, 1'b0); step();
        drain_req_i = 1'b1; lsu_req_i = mk(32'h602);
        @(negedge clk_i);
        check("t4_no_issue0", 32'(dc_req_valid_o), 32'd0);
        check("t4_drained0", 32'(drained_o), 32'd0);
        step();
        @(negedge clk_i);
        check("t4_no_issue1", 32'(dc_req_valid_o), 32'd0);
        step();
        rsp(c_SID_LSU, 32'hD1, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        check("t4_drained_r1", 32'(drained_o), 32'd0);
        step();
        rsp(c_SID_LSU, 32'hD2, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        check("t4_drained_r2", 32'(drained_o), 32'd0);
        step();
        dc_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        check("t4_drained_set", 32'(drained_o), 32'd1);
        check("t4_no_issue2", 32'(dc_req_valid_o), 32'd0);
        step();
        drain_req_i = 1'b0;
        push_req(c_SID_LSU, 32'h602, 1'b1, 1'b0);
        step();
        @(negedge clk_i);
        check("t4_drained_clear", 32'(drained_o), 32'd0);
        step();
        lsu_req_valid_i = 1'b0;
        rsp(c_SID_LSU, 32'hD3, 1'b1, 1'b0, 1'b0); step();
        dc_rsp_valid_i = 1'b0;

        // 5: unknown SID with one LSU in flight, then underflow
        lsu_req_valid_i = 1'b1; lsu_req_i = mk(32'h700);
        push_req(c_SID_LSU, 32'h700, 1'b1, 1'b0);
        step();
        lsu_req_valid_i = 1'b0;
        rsp(3'b111, 32'hE0, 1'b0, 1'b0, 1'b1);
        step();
        dc_rsp_valid_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            lsu_req_valid_i = 1'b1; lsu_req_i = mk(32'h700 + 32'(i));
            push_req(c_SID_LSU, 32'h700 + 32'(i), 1'b1, 1'b0);
            @(negedge clk_i);
            check("t5_err_pulse", 32'(err_sid_o), 32'd0);
            step();
        end
        lsu_req_i = mk(32'h704);
        @(negedge clk_i);
        check("t5_count_kept", 32'(dc_req_valid_o), 32'd0);
        step();
        lsu_req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rsp(c_SID_LSU, 32'hE1 + 32'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        rsp(c_SID_LSU, 32'hEF, 1'b1, 1'b0, 1'b1);
        step();
        dc_rsp_valid_i = 1'b0;
        step();

`ifdef DCACHE_ARB_STARVE_GUARD_EN
        // 6: LSU forced on the 9th accept
        lsu_req_valid_i = 1'b1; lsu_req_i = mk(32'h800);
        ptw_req_valid_i = 1'b1; ptw_req_i = mk(32'h900);
        for (int k = 0; k < 9; k++) begin
            if (k >= 1) rsp(c_SID_PTW, 32'hF0 + 32'(k), 1'b0, 1'b1, 1'b0);
            if (k < 8) push_req(c_SID_PTW, 32'h900, 1'b0, 1'b1);
            else       push_req(c_SID_LSU, 32'h800, 1'b1, 1'b0);
            step();
        end
        lsu_req_valid_i = 1'b0; ptw_req_valid_i = 1'b0;
        rsp(c_SID_LSU, 32'hFF, 1'b1, 1'b0, 1'b0);
        step();
        dc_rsp_valid_i = 1'b0;
`endif

        dc_req_ready_i = 1'b0;
        repeat (2) step();
        check("req_queue_drained", 32'(q_req.size()), 32'd0);
        check("rsp_queue_drained", 32'(q_rsp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
